// File: rtl/flag_writer.sv
// NZCV flag producer: captures execute-stage flags into a one-deep pending register,
// forwards them immediately, and commits them to the architectural flags.
// Optional shadow save/restore is built when FLAG_SHADOW_EN is defined.
module flag_writer #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_valid,
    input  logic [3:0] ex_flags,
    input  logic [1:0] ex_flag_w,
    input  logic       ex_cond_ex,
    input  logic       stall,
    input  logic       flush,
    input  logic       save,
    input  logic       restore,
    output logic [3:0] flags,
    output logic [3:0] flags_arch,
    output logic       pend_valid,
    output logic       shadow_valid
);

    // w[1] selects the N,Z pair from upd, w[0] selects the C,V pair.
    function automatic logic [3:0] merge_flags(input logic [3:0] base,
                                               input logic [3:0] upd,
                                               input logic [1:0] w);
        merge_flags = {w[1] ? upd[3:2] : base[3:2],
                       w[0] ? upd[1:0] : base[1:0]};
    endfunction

    logic [3:0] arch_q, arch_d;
    logic [3:0] pend_flags_q, pend_flags_d;
    logic [1:0] pend_w_q, pend_w_d;
    logic       pend_valid_q, pend_valid_d;
    logic       cap;
    logic [3:0] fwd_flags;

    assign cap       = ex_valid & ex_cond_ex & (|ex_flag_w) & ~stall & ~flush;
    assign fwd_flags = pend_valid_q ? merge_flags(arch_q, pend_flags_q, pend_w_q) : arch_q;

    assign flags      = fwd_flags;
    assign flags_arch = arch_q;
    assign pend_valid = pend_valid_q;

`ifdef FLAG_SHADOW_EN
    logic [3:0] shadow_q, shadow_d;
    logic       shadow_valid_q, shadow_valid_d;
    logic       restore_eff;

    assign restore_eff  = restore & shadow_valid_q;
    assign shadow_valid = shadow_valid_q;
`else
    logic unused_shadow_ports;
    assign unused_shadow_ports = save ^ restore;
    assign shadow_valid        = 1'b0;
`endif

    always_comb begin
        arch_d       = arch_q;
        pend_flags_d = pend_flags_q;
        pend_w_d     = pend_w_q;
        pend_valid_d = pend_valid_q;
`ifdef FLAG_SHADOW_EN
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
`endif

        if (pend_valid_q && !stall) begin
            arch_d       = merge_flags(arch_q, pend_flags_q, pend_w_q);
            pend_valid_d = 1'b0;
        end

        if (cap) begin
            pend_flags_d = ex_flags;
            pend_w_d     = ex_flag_w;
            pend_valid_d = 1'b1;
        end

`ifdef FLAG_SHADOW_EN
        // A valid restore overrides commit, capture and save in the same cycle.
        if (restore_eff) begin
            arch_d         = shadow_q;
            pend_flags_d   = pend_flags_q;
            pend_w_d       = pend_w_q;
            pend_valid_d   = 1'b0;
            shadow_valid_d = 1'b0;
        end else if (save) begin
            shadow_d       = fwd_flags;
            shadow_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arch_q       <= FLAGS_RESET;
            pend_flags_q <= 4'b0000;
            pend_w_q     <= 2'b00;
            pend_valid_q <= 1'b0;
        end else begin
            arch_q       <= arch_d;
            pend_flags_q <= pend_flags_d;
            pend_w_q     <= pend_w_d;
            pend_valid_q <= pend_valid_d;
        end
    end

`ifdef FLAG_SHADOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q       <= FLAGS_RESET;
            shadow_valid_q <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_flag_writer.sv
// Self-checking bench for flag_writer: directed test-plan steps followed by random
// traffic, all compared against a flag-level reference model.
module tb_flag_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid;
    logic [3:0] ex_flags;
    logic [1:0] ex_flag_w;
    logic       ex_cond_ex;
    logic       stall;
    logic       flush;
    logic       save;
    logic       restore;
    logic [3:0] flags;
    logic [3:0] flags_arch;
    logic       pend_valid;
    logic       shadow_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [3:0] m_arch;
    logic [3:0] m_pend_f;
    logic [1:0] m_pend_w;
    logic       m_pend_v;
    logic [3:0] m_shadow;
    logic       m_shadow_v;

`ifdef FLAG_SHADOW_EN
    localparam bit SHADOW_EN = 1'b1;
`else
    localparam bit SHADOW_EN = 1'b0;
`endif

    flag_writer #(.FLAGS_RESET(4'b0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_flags    (ex_flags),
        .ex_flag_w   (ex_flag_w),
        .ex_cond_ex  (ex_cond_ex),
        .stall       (stall),
        .flush       (flush),
        .save        (save),
        .restore     (restore),
        .flags       (flags),
        .flags_arch  (flags_arch),
        .pend_valid  (pend_valid),
        .shadow_valid(shadow_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] overlay(input logic [3:0] base, input logic [3:0] f,
                                           input logic [1:0] w);
        logic [3:0] mask;
        mask = {w[1], w[1], w[0], w[0]};
        return (base & ~mask) | (f & mask);
    endfunction

    function automatic logic [3:0] m_fwd();
        return m_pend_v ? overlay(m_arch, m_pend_f, m_pend_w) : m_arch;
    endfunction

    task automatic model_reset();
        m_arch = 4'b0000; m_pend_f = 4'b0000; m_pend_w = 2'b00; m_pend_v = 1'b0;
        m_shadow = 4'b0000; m_shadow_v = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] fwd;
        logic       do_cap;
        fwd    = m_fwd();
        do_cap = ex_valid && ex_cond_ex && (ex_flag_w != 2'b00) && !stall && !flush;
        if (SHADOW_EN && restore && m_shadow_v) begin
            m_arch = m_shadow; m_pend_v = 1'b0; m_shadow_v = 1'b0;
        end else begin
            if (m_pend_v && !stall) begin
                m_arch = overlay(m_arch, m_pend_f, m_pend_w); m_pend_v = 1'b0;
            end
            if (do_cap) begin
                m_pend_f = ex_flags; m_pend_w = ex_flag_w; m_pend_v = 1'b1;
            end
            if (SHADOW_EN && save) begin
                m_shadow = fwd; m_shadow_v = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".flags"}, flags, m_fwd());
        chk({tag, ".arch"}, flags_arch, m_arch);
        chk({tag, ".pend"}, {3'b000, pend_valid}, {3'b000, m_pend_v});
        chk({tag, ".shv"}, {3'b000, shadow_valid}, {3'b000, m_shadow_v});
        $display("[%0t] %s ex_v=%b f=%b w=%b ce=%b st=%b fl=%b sv=%b rs=%b -> flags=%b arch=%b pend=%b shv=%b",
                 $time, tag, ex_valid, ex_flags, ex_flag_w, ex_cond_ex, stall, flush, save, restore,
                 flags, flags_arch, pend_valid, shadow_valid);
    endtask

    task automatic drive(input logic v, input logic [3:0] f, input logic [1:0] w, input logic ce,
                         input logic st, input logic fl, input logic sv, input logic rs);
        ex_valid = v; ex_flags = f; ex_flag_w = w; ex_cond_ex = ce;
        stall = st; flush = fl; save = sv; restore = rs;
    endtask

    task automatic idle();
        drive(1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock edge: model advances on the same inputs, outputs checked 1 ns later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        model_reset();

        // Asynchronous reset asserted mid-clock must act without an edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset.flags", flags, 4'b0000);
        chk("reset.arch", flags_arch, 4'b0000);
        chk("reset.pend", {3'b000, pend_valid}, 4'b0000);
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write
        drive(1'b1, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("basic.cap");
        chk("basic.fwd", flags, 4'b0100);
        idle();
        cycle("basic.commit");
        chk("basic.arch", flags_arch, 4'b0100);

        // Partial write over arch=1100
        drive(1'b1, 4'b1100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("partial.setup");
        idle();
        cycle("partial.setup2");
        drive(1'b1, 4'b0011, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("partial.cap");
        chk("partial.fwd", flags, 4'b1111);
        idle();
        cycle("partial.commit");
        chk("partial.arch", flags_arch, 4'b1111);
        drive(1'b1, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("partial.noce");
        chk("partial.noce_pend", {3'b000, pend_valid}, 4'b0000);
        chk("partial.noce_flags", flags, 4'b1111);

        // Back-to-back writes then stall
        drive(1'b1, 4'b1000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("b2b.w1");
        chk("b2b.fwd1", flags, 4'b1000);
        drive(1'b1, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("b2b.w2");
        chk("b2b.fwd2", flags, 4'b0100);
        drive(1'b0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("b2b.stall");
            chk("b2b.stall_arch", flags_arch, 4'b1000);
            chk("b2b.stall_pend", {3'b000, pend_valid}, 4'b0001);
        end
        idle();
        cycle("b2b.release");
        chk("b2b.release_arch", flags_arch, 4'b0100);

        // Flush blocks capture but not the older pending commit
        drive(1'b1, 4'b0010, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("flush.pend");
        drive(1'b1, 4'b0001, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("flush.kill");
        chk("flush.arch", flags_arch, 4'b0010);
        chk("flush.flags", flags, 4'b0010);
        idle();
        cycle("flush.after");
        chk("flush.arch2", flags_arch, 4'b0010);

        // Shadow save / restore against a same-cycle capture
        drive(1'b1, 4'b0110, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("shadow.set");
        drive(1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("shadow.save");
        drive(1'b1, 4'b1001, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("shadow.w");
        drive(1'b1, 4'b0001, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("shadow.restore");
        idle();
        cycle("shadow.after");
`ifdef FLAG_SHADOW_EN
        chk("shadow.on_arch", flags_arch, 4'b0110);
        chk("shadow.on_flags", flags, 4'b0110);
        chk("shadow.on_shv", {3'b000, shadow_valid}, 4'b0000);
`else
        chk("shadow.off_arch", flags_arch, 4'b0001);
        chk("shadow.off_shv", {3'b000, shadow_valid}, 4'b0000);
`endif

        // Random traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
            if ($urandom_range(0, 49) == 0) begin
                #1;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rand.reset");
                rst_n = 1'b1;
            end
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
